// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and an
// optional second (skid) entry so that in_ready can come straight from a flop.
// Carries a debug PC alongside the payload and counts downstream stall cycles.
module pipe_stage_skid #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter logic [31:0]      RESET_PC  = 32'hbfc00000,
    parameter int               SKID      = 1,
    parameter int               CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [31:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [31:0]      out_pc,
    output logic [CNT_W-1:0] stall_cnt
);

    // Occupancy: nothing stored, head only, head plus skid entry.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       r_state;
    logic             r_main_valid;
    logic [WIDTH-1:0] r_main_data;
    logic [31:0]      r_main_pc;
    logic [WIDTH-1:0] r_skid_data;
    logic [31:0]      r_skid_pc;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_stall_cnt;

    logic       w_acc;
    logic       w_iss;
    logic       w_in_ready;
    logic [1:0] w_state_nxt;
    logic       w_load_head_in;
    logic       w_load_head_skid;
    logic       w_load_skid;

    // With a skid entry the ready is a flop; without one it must look at
    // out_ready so a full head can be replaced in the same cycle it issues.
    assign w_in_ready = (SKID != 0) ? r_in_ready : (~r_main_valid | out_ready);
    assign w_acc      = in_valid & w_in_ready;
    assign w_iss      = r_main_valid & out_ready;

    // Next occupancy and which storage entry loads from where this cycle.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_head_in   = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_acc) begin
                    w_state_nxt    = ST_ONE;
                    w_load_head_in = 1'b1;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (w_acc && w_iss) begin
                    w_state_nxt    = ST_ONE;
                    w_load_head_in = 1'b1;
                end else if (w_acc) begin
                    w_state_nxt = ST_TWO;
                    w_load_skid = 1'b1;
                end else if (w_iss) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_ONE;
                end
            end
            ST_TWO: begin
                if (w_iss) begin
                    w_state_nxt      = ST_ONE;
                    w_load_head_skid = 1'b1;
                end else begin
                    w_state_nxt = ST_TWO;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Occupancy, head/skid storage and the registered in_ready; flush wins
    // over any accept or issue in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_EMPTY;
            r_main_valid <= 1'b0;
            r_main_data  <= RESET_VAL;
            r_main_pc    <= RESET_PC;
            r_skid_data  <= RESET_VAL;
            r_skid_pc    <= RESET_PC;
            r_in_ready   <= 1'b1;
        end else if (flush) begin
            r_state      <= ST_EMPTY;
            r_main_valid <= 1'b0;
            r_main_data  <= RESET_VAL;
            r_main_pc    <= RESET_PC;
            r_skid_data  <= RESET_VAL;
            r_skid_pc    <= RESET_PC;
            r_in_ready   <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_main_valid <= (w_state_nxt != ST_EMPTY);
            r_in_ready   <= (w_state_nxt != ST_TWO);
            if (w_load_head_in) begin
                r_main_data <= in_data;
                r_main_pc   <= in_pc;
            end else if (w_load_head_skid) begin
                r_main_data <= r_skid_data;
                r_main_pc   <= r_skid_pc;
            end else begin
                r_main_data <= r_main_data;
                r_main_pc   <= r_main_pc;
            end
            if (w_load_skid) begin
                r_skid_data <= in_data;
                r_skid_pc   <= in_pc;
            end else begin
                r_skid_data <= r_skid_data;
                r_skid_pc   <= r_skid_pc;
            end
        end
    end

    // Saturating count of cycles where a beat waits on downstream; flush
    // deliberately leaves it alone.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= {CNT_W{1'b0}};
        end else if (r_main_valid && !out_ready && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;
    assign out_pc    = r_main_pc;
    assign stall_cnt = r_stall_cnt;

endmodule
